aes256_key_sched_ctrl: RTL and testbench
========================================

# aes256_key_sched_ctrl

- Sequences AES-256 key expansion: accepts a 256-bit cipher key over a valid/ready handshake and drives the one-step expansion module (Round_Key_Value_256_BIT) seven times with the correct round constant.
- Stores round keys RK0..RK14 (128 bits each) in an internal key store and serves them through a registered read port.
- Sits between the key-load interface and the AES-256 round datapath, which reads one round key per round.

## Interface
Parameters:
- STEP_LAT, 2: cycles from presenting PREVIOUS_KEY until NEW_KEY is valid. Covers the clocked Sub_Word stages. Legal range 0..7.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- KEY_IN  in  [0:255]  cipher key, MSB-first word order (W0 = [0:31])
- KEY_VALID  in  1  KEY_IN valid
- KEY_READY  out  1  controller can accept a key
- RK_IDX  in  [3:0]  round-key read index
- RK_OUT  out  [0:127]  round key RK_IDX, registered
- RK_VALID  out  1  all 15 round keys stored and valid
- BUSY  out  1  expansion in progress
- DONE  out  1  one-cycle pulse when expansion completes
- ZEROIZE  in  1  present only under KEY_SCHED_ZEROIZE_EN

## Operation
States:
- IDLE → LOAD on KEY_VALID & KEY_READY. KEY_READY = 1 in IDLE and DONE_ST only.
- LOAD: write RK0 = KEY_IN[0:127] and RK1 = KEY_IN[128:255]. Working register ← KEY_IN; step ← 0; lat_cnt ← 0. Go to STEP.
- STEP: working register drives PREVIOUS_KEY; Round_Constant = {rcon[step], 24'h0}.
  - rcon = 01, 02, 04, 08, 10, 20, 40.
  - lat_cnt increments each cycle. When lat_cnt == STEP_LAT, capture NEW_KEY: RK[2·step+2] ← NEW_KEY[0:127] and RK[2·step+3] ← NEW_KEY[128:255]. Working ← NEW_KEY; lat_cnt ← 0; step++.
  - step 6 writes RK14 only; NEW_KEY[128:255] is discarded. After the step-6 capture go to DONE_ST.
- DONE_ST: RK_VALID = 1; DONE pulses on the entry cycle only. Stays here until a new key handshake, which returns to LOAD.
- Re-key: accepting a new key clears RK_VALID in the same cycle as LOAD. Old keys are unreadable from that point.
- KEY_VALID while BUSY is ignored (KEY_READY = 0); no queuing.
- Read port: RK_OUT ← (RK_VALID && RK_IDX ≤ 14) ? RK[RK_IDX] : 0, registered. RK_IDX 15 returns 0.
- BUSY = 1 in LOAD and STEP.
- Arithmetic: step is a 3-bit counter; lat_cnt is 3-bit. No wrap occurs inside the legal range.

## Timing
- Reset values: KEY_READY = 1 on the first cycle after reset; BUSY = 0; DONE = 0; RK_VALID = 0; RK_OUT = 0. State = IDLE; key store cleared to 0.
- Reset mid-expansion aborts immediately: no partial keys remain readable and no DONE pulse is produced.
- Accept at edge t0: LOAD in cycle t0+1. Each step takes STEP_LAT+1 cycles.
- RK_VALID and DONE assert in cycle t0+2+7·(STEP_LAT+1). For STEP_LAT = 2 that is t0+23.
- Read latency is 1 cycle: RK_IDX sampled at edge t appears on RK_OUT after edge t.
- RK_IDX changing every cycle yields back-to-back reads.

## Configuration
- KEY_SCHED_ZEROIZE_EN defined:
  - ZEROIZE port exists. Synchronous ZEROIZE = 1 clears the key store and working register, forces RK_VALID = 0 and RK_OUT = 0, and returns to IDLE on the next cycle.
  - Priority: RST > ZEROIZE > key handshake. A key presented in the same cycle as ZEROIZE is not accepted.
- Not defined: no ZEROIZE port. Keys persist until RST or re-key.

## Structure
- Shared package aes_pkg holds:
  - state enum (IDLE, LOAD, STEP, DONE_ST)
  - AES256_NUM_RK = 15, AES256_NUM_STEPS = 7
  - 7-entry rcon table
  - round-key type [0:127]
- One sub-module: Round_Key_Value_256_BIT, instantiated once and reused for all seven steps. Its CLK is tied to CLK.
- Key store: 15×128 register array inside this block.

## Test plan
- FIPS-197 C.3 key 000102…1e1f, STEP_LAT = 2:
  - RK_VALID at t0+23 with a single DONE pulse.
  - RK0 = 000102…0f; RK1 = 101112…1f.
  - RK2 = a573c29fa176c498a97fce93a572c09c.
  - RK14 = 24fc79ccbf0979e9371ac23c6d68de36.
- KEY_VALID held high throughout expansion with a different key → ignored; results match the first key. After DONE, the second key is accepted and RK_VALID drops in the LOAD cycle.
- RST asserted at step 3 → next cycle: RK_VALID = 0, RK_OUT = 0, KEY_READY = 1; a later full run gives correct FIPS keys.
- RK_IDX = 15 after completion → RK_OUT = 0. RK_IDX = 14 before completion → RK_OUT = 0.
- STEP_LAT = 0 and STEP_LAT = 3 → identical keys; RK_VALID at t0+9 and t0+30 respectively.
- KEY_SCHED_ZEROIZE_EN: ZEROIZE pulse after completion → RK_VALID = 0 and all reads 0. ZEROIZE concurrent with KEY_VALID → key not accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 key schedule controller:
// FSM state codes, schedule sizes, round-constant table, round-key type
// and the byte substitution used by the one-step expansion.
package aes_pkg;

    localparam int AES256_NUM_RK    = 15;
    localparam int AES256_NUM_STEPS = 7;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] STEP    = 2'd2;
    localparam logic [1:0] DONE_ST = 2'd3;

    localparam logic [7:0] RCON_TAB [0:AES256_NUM_STEPS-1] =
        '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    typedef logic [0:127] rk_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, so 0 maps to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gf_mul(inv, p);
            p = gf_mul(p, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/Round_Key_Value_256_BIT.sv
// One AES-256 key-expansion step: eight words in, the next eight words out.
// The substitution result is delayed by STEP_LAT clocked stages so the
// caller sees NEW_KEY valid STEP_LAT cycles after PREVIOUS_KEY is presented
// (PREVIOUS_KEY must be held stable for that long).
module Round_Key_Value_256_BIT
    import aes_pkg::*;
#(
    parameter int STEP_LAT = 2
) (
    input  logic         CLK,
    input  logic [0:255] PREVIOUS_KEY,
    input  logic [31:0]  Round_Constant,
    output logic [0:255] NEW_KEY
);

    logic [31:0]  w [0:7];
    logic [31:0]  n [0:7];
    logic [0:255] next_key;

    // Word recurrence: first half uses RotWord/SubWord/rcon, second half SubWord only
    always_comb begin
        next_key = '0;
        for (int i = 0; i < 8; i++) w[i] = PREVIOUS_KEY[32*i +: 32];
        n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ Round_Constant;
        for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
        n[4] = w[4] ^ sub_word(n[3]);
        for (int i = 5; i < 8; i++) n[i] = w[i] ^ n[i-1];
        for (int i = 0; i < 8; i++) next_key[32*i +: 32] = n[i];
    end

    generate
        if (STEP_LAT == 0) begin : g_comb
            logic clk_unused;
            assign clk_unused = CLK;
            assign NEW_KEY    = next_key;
        end else begin : g_pipe
            logic [0:255] pipe [0:STEP_LAT-1];
            // Delay line standing in for the clocked substitution stages
            always_ff @(posedge CLK) begin
                pipe[0] <= next_key;
                for (int i = 1; i < STEP_LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign NEW_KEY = pipe[STEP_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key schedule controller. Accepts a 256-bit key, runs seven
// expansion steps through one shared Round_Key_Value_256_BIT, stores
// RK0..RK14 and serves them through a registered read port.
// Optional feature macro: KEY_SCHED_ZEROIZE_EN adds a ZEROIZE input that
// wipes all key material and returns to IDLE.
//
//   state   | meaning
//   IDLE    | no valid keys, ready for a key
//   LOAD    | RK0/RK1 written from the accepted key
//   STEP    | one expansion step in flight, waiting STEP_LAT cycles
//   DONE_ST | all 15 round keys valid, ready for a re-key
module aes256_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int STEP_LAT = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [0:255] KEY_IN,
    input  logic         KEY_VALID,
    output logic         KEY_READY,
    input  logic [3:0]   RK_IDX,
    output logic [0:127] RK_OUT,
    output logic         RK_VALID,
    output logic         BUSY,
    output logic         DONE
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    input  logic         ZEROIZE
`endif
);

    localparam logic [2:0] LAT_TC    = 3'(STEP_LAT);
    localparam logic [2:0] LAST_STEP = 3'(AES256_NUM_STEPS - 1);
    localparam logic [3:0] MAX_IDX   = 4'(AES256_NUM_RK - 1);

    logic [1:0]   state;
    logic [0:255] working;
    logic [2:0]   step;
    logic [2:0]   lat_cnt;
    logic         done_q;
    logic [0:127] rk_out_q;
    rk_t          rk_store [0:AES256_NUM_RK-1];
    logic [0:255] new_key;
    logic [3:0]   lo_idx;
    logic [3:0]   hi_idx;
    logic         zeroize;
    logic         key_accept;
    logic         capture;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zeroize = ZEROIZE;
`else
    assign zeroize = 1'b0;
`endif

    assign KEY_READY  = (state == IDLE) || (state == DONE_ST);
    assign key_accept = KEY_VALID && KEY_READY && !zeroize;
    assign capture    = (state == STEP) && (lat_cnt == LAT_TC);
    assign lo_idx     = {step, 1'b0} + 4'd2;
    assign hi_idx     = lo_idx + 4'd1;
    assign RK_VALID   = (state == DONE_ST);
    assign BUSY       = (state == LOAD) || (state == STEP);
    assign DONE       = done_q;
    assign RK_OUT     = rk_out_q;

    Round_Key_Value_256_BIT #(.STEP_LAT(STEP_LAT)) u_step (
        .CLK            (CLK),
        .PREVIOUS_KEY   (working),
        .Round_Constant ({RCON_TAB[step], 24'h0}),
        .NEW_KEY        (new_key)
    );

    // Sequencer: key capture, step/latency counting and key-store writes.
    // KEY_IN is latched at the handshake so the source may change it right away.
    always_ff @(posedge CLK) begin
        if (RST || zeroize) begin
            state   <= IDLE;
            working <= '0;
            step    <= '0;
            lat_cnt <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < AES256_NUM_RK; i++) rk_store[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    if (key_accept) begin
                        state   <= LOAD;
                        working <= KEY_IN;
                    end
                end
                LOAD: begin
                    rk_store[0] <= working[0:127];
                    rk_store[1] <= working[128:255];
                    step        <= '0;
                    lat_cnt     <= '0;
                    state       <= STEP;
                end
                STEP: begin
                    if (capture) begin
                        rk_store[lo_idx] <= new_key[0:127];
                        if (step != LAST_STEP) rk_store[hi_idx] <= new_key[128:255];
                        working <= new_key;
                        lat_cnt <= '0;
                        if (step == LAST_STEP) begin
                            state  <= DONE_ST;
                            done_q <= 1'b1;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; returns zero unless the full schedule is valid
    always_ff @(posedge CLK) begin
        if (RST || zeroize) begin
            rk_out_q <= '0;
        end else if (RK_VALID && (RK_IDX <= MAX_IDX)) begin
            rk_out_q <= rk_store[RK_IDX];
        end else begin
            rk_out_q <= '0;
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench for aes256_key_sched_ctrl: three instances with
// STEP_LAT = 0, 2, 3 against a word-level FIPS-197 key-schedule model.
module tb_aes256_key_sched_ctrl;

    localparam logic [0:255] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         CLK = 1'b0;
    logic         RST;
    logic [0:255] KEY_IN;
    logic [3:0]   rk_idx;
    logic         zeroize;
    logic         kv     [3];
    logic         kr     [3];
    logic         rkv    [3];
    logic         busy   [3];
    logic         done   [3];
    logic [0:127] rk_out [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   tb_sbox [256];
    logic [127:0] m_rk    [15];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes256_key_sched_ctrl #(.STEP_LAT(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .KEY_IN    (KEY_IN),
            .KEY_VALID (kv[g]),
            .KEY_READY (kr[g]),
            .RK_IDX    (rk_idx),
            .RK_OUT    (rk_out[g]),
            .RK_VALID  (rkv[g]),
            .BUSY      (busy[g]),
            .DONE      (done[g])
`ifdef KEY_SCHED_ZEROIZE_EN
            ,
            .ZEROIZE   (zeroize)
`endif
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (xmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            tb_sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    // Full 60-word FIPS-197 schedule, round key k = words 4k..4k+3
    task automatic model_expand(input logic [0:255] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) m_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [0:255] rand_key();
        logic [0:255] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic start_key(input int d, input logic [0:255] key, input bit hold,
                             input logic [0:255] other);
        @(negedge CLK);
        KEY_IN = key;
        kv[d]  = 1'b1;
        rk_idx = 4'd14;
        chk("key_ready", kr[d], 1);
        @(posedge CLK);
        #1;
        if (hold) KEY_IN = other;
        else kv[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int exp_n);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                chk("load_busy", busy[d], 1);
                chk("load_rk_valid", rkv[d], 0);
            end
            if (n == 2) chk("busy_not_ready", kr[d], 0);
            if (rkv[d]) seen = 1;
            else if (done[d]) chk("early_done", done[d], 0);
        end
        kv[d] = 1'b0;
        chk("rk_valid_latency", n, exp_n);
        chk("done_pulse", done[d], 1);
        chk("pre_valid_read", rk_out[d], 0);
        @(negedge CLK);
        chk("done_single", done[d], 0);
        chk("rk14_first_read", rk_out[d], m_rk[14]);
    endtask

    task automatic read_all(input int d, input bit zero);
        logic [127:0] exp;
        for (int i = 0; i <= 16; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                if (zero || i - 1 > 14) exp = '0;
                else exp = m_rk[i-1];
                chk($sformatf("read_rk%0d_dut%0d", i - 1, d), rk_out[d], exp);
            end
            if (i < 16) rk_idx = 4'(i);
        end
    endtask

    task automatic read_idx(input int d, input logic [3:0] idx, output logic [127:0] v);
        @(negedge CLK);
        rk_idx = idx;
        @(negedge CLK);
        v = rk_out[d];
    endtask

    initial begin
        logic [0:255] ka;
        logic [0:255] kb;
        logic [127:0] v;
        int dones;

        RST     = 1'b1;
        zeroize = 1'b0;
        KEY_IN  = '0;
        rk_idx  = 4'd0;
        for (int d = 0; d < 3; d++) kv[d] = 1'b0;
        build_sbox();

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            chk("rst_key_ready", kr[d], 1);
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_rk_valid", rkv[d], 0);
            chk("rst_rk_out", rk_out[d], 0);
        end

        // FIPS-197 C.3 key, STEP_LAT = 2
        model_expand(FIPS_KEY);
        start_key(1, FIPS_KEY, 0, '0);
        wait_valid(1, 23);
        read_all(1, 0);
        read_idx(1, 4'd0, v);  chk("fips_rk0", v, 128'h000102030405060708090a0b0c0d0e0f);
        read_idx(1, 4'd1, v);  chk("fips_rk1", v, 128'h101112131415161718191a1b1c1d1e1f);
        read_idx(1, 4'd2, v);  chk("fips_rk2", v, 128'ha573c29fa176c498a97fce93a572c09c);
        read_idx(1, 4'd14, v); chk("fips_rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_idx(1, 4'd15, v); chk("idx15_zero", v, 0);

        // KEY_VALID held through expansion with another key: ignored, then re-key
        ka = rand_key();
        kb = rand_key();
        model_expand(ka);
        start_key(1, ka, 1, kb);
        wait_valid(1, 23);
        read_all(1, 0);
        model_expand(kb);
        start_key(1, kb, 0, '0);
        wait_valid(1, 23);
        read_all(1, 0);

        // Reset during step 3 aborts with no DONE
        model_expand(FIPS_KEY);
        start_key(1, FIPS_KEY, 0, '0);
        repeat (11) @(negedge CLK);
        chk("mid_busy", busy[1], 1);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_rk_valid", rkv[1], 0);
        chk("abort_rk_out", rk_out[1], 0);
        chk("abort_key_ready", kr[1], 1);
        chk("abort_busy", busy[1], 0);
        dones = 0;
        repeat (30) begin
            @(negedge CLK);
            if (done[1]) dones++;
        end
        chk("abort_no_done", dones, 0);
        start_key(1, FIPS_KEY, 0, '0);
        wait_valid(1, 23);
        read_all(1, 0);

        // STEP_LAT = 0 and 3 give the same keys with their own latency
        start_key(0, FIPS_KEY, 0, '0);
        wait_valid(0, 9);
        read_all(0, 0);
        start_key(2, FIPS_KEY, 0, '0);
        wait_valid(2, 30);
        read_all(2, 0);

        // Random keys on each latency variant
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++) begin
                ka = rand_key();
                model_expand(ka);
                start_key(d, ka, 0, '0);
                wait_valid(d, 2 + 7 * ((d == 0 ? 0 : (d == 1 ? 2 : 3)) + 1));
                read_all(d, 0);
            end
        end

`ifdef KEY_SCHED_ZEROIZE_EN
        @(negedge CLK);
        zeroize = 1'b1;
        @(posedge CLK);
        #1 zeroize = 1'b0;
        @(negedge CLK);
        chk("zeroize_rk_valid", rkv[1], 0);
        chk("zeroize_ready", kr[1], 1);
        read_all(1, 1);
        @(negedge CLK);
        KEY_IN  = rand_key();
        kv[1]   = 1'b1;
        zeroize = 1'b1;
        @(posedge CLK);
        #1;
        kv[1]   = 1'b0;
        zeroize = 1'b0;
        @(negedge CLK);
        chk("zeroize_blocks_key", busy[1], 0);
        chk("zeroize_blocks_valid", rkv[1], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
